hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It watches the instructions in ID and EX and drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It covers three cases:
- load-use stalls;
- multi-cycle EX operations (mul/div), which hold EX for a fixed latency;
- taken-branch squashing of the instruction in IF/ID.

It also keeps a saturating count of stall cycles for performance analysis.

---
 rtl/hazard_stall_ctrl.sv | 66 ++++++
 tb/tb_hazard_stall_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, multi-cycle EX hold and branch squash control for the 5-stage pipeline
module hazard_stall_ctrl #(
   parameter int MULTI_LAT = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             EX_memRead,
   input  logic [4:0]       EX_rt,
   input  logic             EX_multi,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_write,
   output logic             IDEX_bubble,
   output logic             EXMEM_bubble,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cycles
);
   typedef enum logic {RUN, MULTI} state_t;
   localparam logic [3:0] CNT_LOAD = 4'(MULTI_LAT > 1 ? MULTI_LAT - 2 : 0);
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             start, lu, hold, lu_stall;
   always_comb begin
      start = state_q == RUN && EX_multi && MULTI_LAT > 1;
      lu = state_q == RUN && EX_memRead && EX_rt != 5'd0 &&
           (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt));
      hold = !rst && (start || (state_q == MULTI && cnt_q != 4'd0));
      lu_stall = !rst && lu && !hold;
      pc_write = !(hold || lu_stall);
      IFID_write = pc_write;
      IFID_flush = !rst && pc_write && branch_taken;
      IDEX_write = !hold;
      IDEX_bubble = lu_stall;
      EXMEM_bubble = hold;
      busy = !rst && state_q == MULTI;
      state_d = state_q;
      cnt_d = cnt_q;
      if (start) begin
         state_d = MULTI;
         cnt_d = CNT_LOAD;
      end else if (state_q == MULTI) begin
         state_d = cnt_q != 4'd0 ? MULTI : RUN;
         cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
      end
      stall_cycles_d = (!pc_write && stall_cycles_q != '1) ? stall_cycles_q + 1'b1 : stall_cycles_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q <= 4'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end
   assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors into a scoreboard queue, checked by an independent negedge monitor
module tb_hazard_stall_ctrl;
   // control word: {pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble, busy}
   localparam logic [6:0] DEF   = 7'b1101000;
   localparam logic [6:0] FLUSH = 7'b1111000;
   localparam logic [6:0] LU    = 7'b0001100;
   localparam logic [6:0] HOLD0 = 7'b0000010;
   localparam logic [6:0] HOLD1 = 7'b0000011;
   localparam logic [6:0] REL   = 7'b1101001;
   localparam logic [6:0] RELF  = 7'b1111001;

   typedef struct {
      int         sel;
      logic [6:0] ctl;
      int         cnt;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_ur, a_mr, a_mu, a_br;
   logic [4:0] a_rs, a_rt, a_ert;
   logic       b_rst, b_ur, b_mr, b_mu, b_br;
   logic [4:0] b_rs, b_rt, b_ert;
   logic       a_pc, a_ifw, a_fl, a_idw, a_idb, a_exb, a_busy;
   logic       b_pc, b_ifw, b_fl, b_idw, b_idb, b_exb, b_busy;
   logic [31:0] a_cnt;
   logic [3:0]  b_cnt;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   hazard_stall_ctrl #(.MULTI_LAT(4), .CNT_W(32)) dut_a (
      .clk(clk), .rst(a_rst), .ID_rs(a_rs), .ID_rt(a_rt), .ID_uses_rt(a_ur),
      .EX_memRead(a_mr), .EX_rt(a_ert), .EX_multi(a_mu), .branch_taken(a_br),
      .pc_write(a_pc), .IFID_write(a_ifw), .IFID_flush(a_fl), .IDEX_write(a_idw),
      .IDEX_bubble(a_idb), .EXMEM_bubble(a_exb), .busy(a_busy), .stall_cycles(a_cnt));

   hazard_stall_ctrl #(.MULTI_LAT(8), .CNT_W(4)) dut_b (
      .clk(clk), .rst(b_rst), .ID_rs(b_rs), .ID_rt(b_rt), .ID_uses_rt(b_ur),
      .EX_memRead(b_mr), .EX_rt(b_ert), .EX_multi(b_mu), .branch_taken(b_br),
      .pc_write(b_pc), .IFID_write(b_ifw), .IFID_flush(b_fl), .IDEX_write(b_idw),
      .IDEX_bubble(b_idb), .EXMEM_bubble(b_exb), .busy(b_busy), .stall_cycles(b_cnt));

   always @(negedge clk) begin
      while (q.size() > 0) begin
         automatic exp_t e = q.pop_front();
         automatic logic [6:0] act = e.sel == 0 ? {a_pc, a_ifw, a_fl, a_idw, a_idb, a_exb, a_busy}
                                                : {b_pc, b_ifw, b_fl, b_idw, b_idb, b_exb, b_busy};
         automatic logic [31:0] act_cnt = e.sel == 0 ? a_cnt : {28'd0, b_cnt};
         total += 2;
         if (act !== e.ctl) begin
            bad++;
            $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
         end
         if (act_cnt !== 32'(e.cnt)) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", e.name, act_cnt, e.cnt);
         end
      end
   end

   task automatic drive(input int sel, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic mr, input logic [4:0] ert, input logic mu,
                        input logic br, input logic [6:0] ec, input int ecnt, input string nm);
      exp_t e;
      if (sel == 0) begin
         a_rst = r; a_rs = rs; a_rt = rt; a_ur = ur; a_mr = mr; a_ert = ert; a_mu = mu; a_br = br;
      end else begin
         b_rst = r; b_rs = rs; b_rt = rt; b_ur = ur; b_mr = mr; b_ert = ert; b_mu = mu; b_br = br;
      end
      e.sel = sel; e.ctl = ec; e.cnt = ecnt; e.name = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1; a_rs = 0; a_rt = 0; a_ur = 0; a_mr = 0; a_ert = 0; a_mu = 0; a_br = 0;
      b_rst = 1; b_rs = 0; b_rt = 0; b_ur = 0; b_mr = 0; b_ert = 0; b_mu = 0; b_br = 0;
      @(posedge clk);
      #1;
      //      sel rst rs  rt  ur mr ert mu br  expect cnt name
      drive(0, 1, 8,  0,  0, 1, 8,  0, 1, DEF,   0, "a_rst_forced");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 0, DEF,   0, "a_idle");
      drive(0, 0, 8,  0,  0, 1, 8,  0, 0, LU,    0, "lu_rs");
      drive(0, 0, 8,  0,  0, 0, 8,  0, 0, DEF,   1, "after_lu");
      drive(0, 0, 3,  8,  0, 1, 8,  0, 0, DEF,   1, "rt_unused");
      drive(0, 0, 0,  0,  0, 1, 0,  0, 0, DEF,   1, "rt_zero");
      drive(0, 0, 3,  8,  1, 1, 8,  0, 0, LU,    1, "lu_rt");
      drive(0, 0, 8,  0,  0, 1, 8,  0, 1, LU,    2, "lu_branch");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 1, FLUSH, 3, "branch_flush");
      drive(0, 0, 8,  0,  0, 1, 8,  1, 0, HOLD0, 3, "multi_t");
      drive(0, 0, 0,  0,  0, 0, 0,  1, 1, HOLD1, 4, "multi_t1_br");
      drive(0, 0, 8,  0,  0, 1, 8,  1, 0, HOLD1, 5, "multi_t2_lu");
      drive(0, 0, 0,  0,  0, 0, 0,  1, 0, REL,   6, "multi_release");
      drive(0, 0, 0,  0,  0, 0, 0,  1, 0, HOLD0, 6, "multi2_t");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 0, HOLD1, 7, "multi2_t1");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 0, HOLD1, 8, "multi2_t2");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 1, RELF,  9, "multi2_rel_br");
      drive(0, 0, 0,  0,  0, 0, 0,  0, 0, DEF,   9, "a_end_idle");
      a_rst = 1;
      drive(1, 1, 0,  0,  0, 0, 0,  0, 0, DEF,   0, "b_rst");
      drive(1, 0, 0,  0,  0, 0, 0,  1, 0, HOLD0, 0, "b_multi_t");
      drive(1, 0, 0,  0,  0, 0, 0,  1, 0, HOLD1, 1, "b_multi_t1");
      drive(1, 1, 0,  0,  0, 0, 0,  1, 1, DEF,   2, "b_rst_mid_multi");
      drive(1, 1, 0,  0,  0, 0, 0,  0, 0, DEF,   0, "b_rst_again");
      drive(1, 0, 0,  0,  0, 0, 0,  1, 0, HOLD0, 0, "b_fresh_t");
      for (int i = 1; i <= 6; i++)
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, HOLD1, i, $sformatf("b_fresh_hold%0d", i));
      drive(1, 0, 0,  0,  0, 0, 0,  0, 0, REL,   7, "b_fresh_release");
      for (int i = 0; i < 20; i++)
         drive(1, 0, 5, 0, 0, 1, 5, 0, 0, LU, (7 + i > 15) ? 15 : 7 + i, $sformatf("b_sat%0d", i));
      drive(1, 0, 0,  0,  0, 0, 0,  0, 0, DEF,  15, "b_sat_hold");
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
